// File: rtl/delay_pkg.sv
// Shared mode encodings and delay clamping for inertial_delay_line.
package delay_pkg;

    localparam logic MODE_TRANSPORT = 1'b0;
    localparam logic MODE_INERTIAL  = 1'b1;

    // Effective delay: 0 behaves as 1, anything beyond depth saturates at depth.
    function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned depth);
        if (req == 0) begin
            return 1;
        end
        if (req > depth) begin
            return depth;
        end
        return req;
    endfunction

endpackage

// File: rtl/inertial_delay_ch.sv
// One channel of the delay line: history shift register, inertial run counter
// and the registered output. Optional rejection pulse with INERTIAL_DELAY_REJ_EN.
module inertial_delay_ch
    import delay_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DW      = $clog2(DEPTH + 1),
    parameter logic        RST_VAL = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          reconf,
    input  logic          mode,
    input  logic [DW-1:0] d,
    input  logic          din,
    output logic          dout
`ifdef INERTIAL_DELAY_REJ_EN
    ,
    output logic          rej
`endif
);

    // dout acts as the final stage, so DEPTH-1 history flops cover a delay of DEPTH.
    localparam int unsigned HW = (DEPTH > 1) ? DEPTH - 1 : 1;
    localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IW = $clog2(HW + 1);

    logic [HW-1:0] hist;
    logic [CW-1:0] cnt;
    logic [HW:0]   tap;
    logic [IW-1:0] idx;

    // tap[0] is the live input, tap[j] the input captured j enabled edges ago.
    assign tap = {hist, din};
    assign idx = IW'(d - DW'(1));

    // History, counter and output update on enabled edges only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= RST_VAL;
            hist <= {HW{RST_VAL}};
            cnt  <= '0;
`ifdef INERTIAL_DELAY_REJ_EN
            rej  <= 1'b0;
`endif
        end else begin
`ifdef INERTIAL_DELAY_REJ_EN
            rej <= 1'b0;
`endif
            if (en) begin
                if (reconf) begin
                    // Flush pending data so nothing stale surfaces after the switch.
                    hist <= {HW{dout}};
                    cnt  <= '0;
                end else begin
                    hist <= tap[HW-1:0];
                    if (mode == MODE_TRANSPORT) begin
                        dout <= tap[idx];
                        cnt  <= '0;
                    end else if (din != dout) begin
                        if (DW'(cnt) + DW'(1) == d) begin
                            dout <= din;
                            cnt  <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (cnt != '0) begin
                        cnt <= '0;
`ifdef INERTIAL_DELAY_REJ_EN
                        rej <= 1'b1;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: rtl/inertial_delay_line.sv
// Multi-channel transport/inertial delay line with runtime delay selection.
// INERTIAL_DELAY_REJ_EN adds the rej port flagging swallowed inertial pulses.
module inertial_delay_line
    import delay_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter int unsigned      DEPTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         mode,
    input  logic [$clog2(DEPTH+1)-1:0]   delay,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout
`ifdef INERTIAL_DELAY_REJ_EN
    ,
    output logic [WIDTH-1:0]             rej
`endif
);

    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic          mode_q;
    logic [DW-1:0] d_q;
    logic [DW-1:0] d_c;
    logic          reconf_c;

    // Any change of mode or effective delay turns the edge into a flush edge.
    assign d_c      = DW'(clamp_delay(32'(delay), DEPTH));
    assign reconf_c = (mode != mode_q) || (d_c != d_q);

    // Registered configuration, sampled on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_TRANSPORT;
            d_q    <= DW'(1);
        end else if (en) begin
            mode_q <= mode;
            d_q    <= d_c;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        inertial_delay_ch #(
            .DEPTH   (DEPTH),
            .DW      (DW),
            .RST_VAL (RST_VAL[i])
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .reconf (reconf_c),
            .mode   (mode_q),
            .d      (d_q),
            .din    (din[i]),
            .dout   (dout[i])
`ifdef INERTIAL_DELAY_REJ_EN
            ,
            .rej    (rej[i])
`endif
        );
    end

endmodule

// File: tb/tb_inertial_delay_line.sv
// Scoreboard bench for inertial_delay_line (rej checked when INERTIAL_DELAY_REJ_EN is set).
module tb_inertial_delay_line;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [WIDTH-1:0] dout;
        logic [WIDTH-1:0] rej;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic [DW-1:0]    delay = '0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
`ifdef INERTIAL_DELAY_REJ_EN
    logic [WIDTH-1:0] rej;
`endif

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    // Reference state
    logic [WIDTH-1:0] m_dout;
    logic [WIDTH-1:0] m_hist [DEPTH];
    int               m_cnt  [WIDTH];
    logic             m_mode;
    int               m_d;

    inertial_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL('0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .delay (delay),
        .din   (din),
        .dout  (dout)
`ifdef INERTIAL_DELAY_REJ_EN
        ,
        .rej   (rej)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dout = '0;
        for (int j = 0; j < DEPTH; j++) m_hist[j] = '0;
        for (int c = 0; c < WIDTH; c++) m_cnt[c] = 0;
        m_mode = 1'b0;
        m_d    = 1;
    endtask

    // Expected outcome of one clock edge given the inputs in front of it.
    task automatic model_edge(input logic e, input logic m, input int dl,
                              input logic [WIDTH-1:0] di, output logic [WIDTH-1:0] rj);
        int dn;
        logic [WIDTH-1:0] nd;
        rj = '0;
        if (!e) return;
        dn = (dl == 0) ? 1 : ((dl > DEPTH) ? DEPTH : dl);
        if (m != m_mode || dn != m_d) begin
            for (int j = 0; j < DEPTH; j++) m_hist[j] = m_dout;
            for (int c = 0; c < WIDTH; c++) m_cnt[c] = 0;
            m_mode = m;
            m_d    = dn;
            return;
        end
        nd = m_dout;
        for (int c = 0; c < WIDTH; c++) begin
            if (!m_mode) begin
                nd[c] = (m_d == 1) ? di[c] : m_hist[m_d - 2][c];
                m_cnt[c] = 0;
            end else if (di[c] != m_dout[c]) begin
                if (m_cnt[c] + 1 == m_d) begin
                    nd[c] = di[c];
                    m_cnt[c] = 0;
                end else begin
                    m_cnt[c]++;
                end
            end else if (m_cnt[c] != 0) begin
                m_cnt[c] = 0;
                rj[c] = 1'b1;
            end
        end
        for (int j = DEPTH - 1; j > 0; j--) m_hist[j] = m_hist[j - 1];
        m_hist[0] = di;
        m_dout = nd;
    endtask

    // Drive one cycle, push the prediction, then compare after the edge.
    task automatic step(input logic e, input logic m, input int dl, input logic [WIDTH-1:0] di);
        exp_t x;
        logic [WIDTH-1:0] rj;
        en = e; mode = m; delay = DW'(dl); din = di;
        model_edge(e, m, dl, di, rj);
        x.dout = m_dout;
        x.rej  = rj;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            check("sb_dout", 32'(dout), 32'(x.dout));
`ifdef INERTIAL_DELAY_REJ_EN
            check("sb_rej", 32'(rej), 32'(x.rej));
`endif
        end
    endtask

    // Assert reset between edges and confirm the output clears immediately.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(dout), 32'd0);
`ifdef INERTIAL_DELAY_REJ_EN
        check("rst_rej", 32'(rej), 32'd0);
`endif
        model_reset();
        sb.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Transport, D=3: step edge latency and a one-tick pulse
        step(1, 0, 3, 4'h0);
        repeat (3) step(1, 0, 3, 4'h0);
        step(1, 0, 3, 4'h1); check("tr_e0", 32'(dout[0]), 32'd0);
        step(1, 0, 3, 4'h1); check("tr_e1", 32'(dout[0]), 32'd0);
        step(1, 0, 3, 4'h1); check("tr_e2", 32'(dout[0]), 32'd1);
        repeat (4) step(1, 0, 3, 4'h0);
        step(1, 0, 3, 4'h1);
        step(1, 0, 3, 4'h0); check("tr_pulse_pre", 32'(dout[0]), 32'd0);
        step(1, 0, 3, 4'h0); check("tr_pulse", 32'(dout[0]), 32'd1);
        step(1, 0, 3, 4'h0); check("tr_pulse_end", 32'(dout[0]), 32'd0);

        // Inertial, D=3: short pulse swallowed, held change passes
        step(1, 1, 3, 4'h0);
        repeat (2) step(1, 1, 3, 4'h0);
        repeat (2) step(1, 1, 3, 4'h2);
        step(1, 1, 3, 4'h0); check("in_short", 32'(dout[1]), 32'd0);
`ifdef INERTIAL_DELAY_REJ_EN
        check("in_rej", 32'(rej[1]), 32'd1);
`endif
        step(1, 1, 3, 4'h2);
        step(1, 1, 3, 4'h2); check("in_hold2", 32'(dout[1]), 32'd0);
        step(1, 1, 3, 4'h2); check("in_hold3", 32'(dout[1]), 32'd1);

        // Inertial, D=5 with en toggling every cycle
        step(1, 1, 5, 4'h2);
        for (int i = 0; i < 10; i++) begin
            step((i % 2) == 0, 1, 5, 4'h6);
            if (i == 6) check("en_tog4", 32'(dout[2]), 32'd0);
            if (i == 8) check("en_tog5", 32'(dout[2]), 32'd1);
            if (i == 9) check("en_tog_hold", 32'(dout[2]), 32'd1);
        end

        // delay=0 behaves as 1, delay=15 saturates at 8
        step(1, 0, 0, 4'h6);
        step(1, 0, 0, 4'h1); check("d0", 32'(dout), 32'h1);
        step(1, 0, 15, 4'h1);
        for (int j = 0; j < 8; j++) begin
            step(1, 0, 15, 4'h8);
            if (j == 6) check("d15_pre", 32'(dout), 32'h1);
            if (j == 7) check("d15", 32'(dout), 32'h8);
        end

        // Switch to inertial while a transport pulse is in flight
        step(1, 0, 4, 4'h0);
        repeat (5) step(1, 0, 4, 4'h0);
        step(1, 0, 4, 4'h8);
        step(1, 1, 4, 4'h0); check("sw_hold", 32'(dout), 32'h0);
        for (int j = 0; j < 6; j++) begin
            step(1, 1, 4, 4'h0);
            if (j == 2) check("sw_no_pulse", 32'(dout[3]), 32'd0);
        end

        // Reset in the middle of an inertial count
        step(1, 1, 3, 4'hA);
        repeat (3) step(1, 1, 3, 4'hA);
        check("rm_pass", 32'(dout), 32'hA);
        repeat (2) step(1, 1, 3, 4'h5);
        do_reset();
        step(1, 1, 3, 4'h5); check("rm_reconf", 32'(dout), 32'h0);
        step(1, 1, 3, 4'h5);
        step(1, 1, 3, 4'h5); check("rm_wait", 32'(dout), 32'h0);
        step(1, 1, 3, 4'h5); check("rm_full", 32'(dout), 32'h5);

        // Randomised traffic with occasional reconfiguration
        begin
            logic rm;
            int   rd;
            rm = 1'b1;
            rd = 3;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 19) == 0) rm = ~rm;
                if ($urandom_range(0, 24) == 0) rd = $urandom_range(0, 15);
                step($urandom_range(0, 3) != 0, rm, rd, 4'($urandom_range(0, 15)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inertial_delay_line.md
# inertial_delay_line

Clocked, synthesizable replacement for the `#`-delay inverter chains used in the delay-model exercises. It delays each of WIDTH independent 1-bit channels by a runtime-selectable number of enabled clock ticks. It runs in one of two modes. Transport mode is a pure delayed copy. Inertial mode passes a level change only after the input has held the new level for the full delay, and swallows shorter pulses. It sits between asynchronous-ish stimulus sources (switches, sensor lines) and downstream synchronous logic, and is the reference model used when teaching transport vs inertial delay on hardware.

## Interface
- WIDTH, 4, number of independent 1-bit channels
- DEPTH, 8, maximum delay in enabled ticks (≥1)
- RST_VAL, '0, WIDTH-bit reset level of dout and all history
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  tick enable; all state advances only on edges with en=1
- mode  input  1  0 = transport, 1 = inertial
- delay  input  $clog2(DEPTH+1)  requested delay in ticks
- din  input  WIDTH  channel inputs
- dout  output  WIDTH  delayed/filtered outputs, registered
- rej  output  WIDTH  one-cycle pulse per channel when an inertial pulse is rejected (present only with the macro)

## Operation
- Effective delay D = 1 if delay==0, DEPTH if delay>DEPTH, else delay.
- Transport mode:
  - Per-channel shift history of DEPTH stages, shifted on each enabled edge.
  - The value on din before enabled edge k appears on dout after enabled edge k+D-1.
  - All pulses pass, including 1-tick pulses.
- Inertial mode uses a per-channel counter cnt (width $clog2(DEPTH)). On each enabled edge:
  - din≠dout and cnt+1==D: dout←din, cnt←0.
  - din≠dout otherwise: cnt←cnt+1.
  - din==dout and cnt≠0: cnt←0; rejection event (rej pulse).
  - din==dout and cnt==0: no change.
- Stable change latency equals transport latency (D enabled edges including capture).
- Reconfiguration:
  - mode and effective D are registered.
  - If either differs from its registered value on an enabled edge, that edge clears all cnt to 0 and loads every history stage with current dout.
  - dout holds across the switch (no glitch). Normal operation resumes on the next enabled edge.
- The history shift register continues updating in inertial mode, and cnt is held at 0 in transport mode, so a mode change never exposes stale data.

## Timing
- Reset (rst_n=0, asynchronous): dout=RST_VAL, history=RST_VAL, cnt=0, rej=0, registered mode=0, registered D=1.
- Reset release: first enabled edge after rst_n rises is treated as a reconfiguration edge if mode/D differ from reset values.
- en=0: no state changes; rej=0.
- rej is asserted for exactly the clk cycle following the rejecting enabled edge, regardless of en.
- D=1, inertial: every change passes after one edge; rej never fires.
- Simultaneous reconfiguration and rejection on one edge: reconfiguration wins, no rej.
- Reset mid-delay: pending changes are discarded.

## Configuration
- INERTIAL_DELAY_REJ_EN defined: rej port and the rejection-detect logic exist as above.
- Not defined: no rej port. Inertial filtering is identical; cnt is simply cleared without signalling.

## Structure
- Package delay_pkg:
  - mode constants MODE_TRANSPORT=1'b0, MODE_INERTIAL=1'b1
  - function clamp_delay(delay, DEPTH) returning D
- Sub-module inertial_delay_ch: one channel's counter, history and output register. Instantiated WIDTH times by generate; the top holds config registers and reconfiguration detect.

## Test plan
- Transport, D=3, en=1: din[0] 0→1 before edge 10 -> dout[0]=1 after edge 12. A 1-tick pulse at edge 20 -> 1-tick pulse after edge 22.
- Inertial, D=3: din[1] high for 2 ticks (edges 5–6) -> dout[1] stays 0; rej[1] pulses after edge 7 (macro on). Held high for 3 ticks from edge 10 -> dout[1]=1 after edge 12.
- Inertial, D=5, en toggling 1/0 every cycle: change held for 5 enabled edges -> passes exactly after 5th enabled edge; unenabled edges ignored.
- delay=0 -> behaves as D=1. delay=15 with DEPTH=8 -> behaves as D=8.
- Mode switch transport→inertial while transport history contains a pending pulse -> dout unchanged at switch, pending pulse never appears, no rej.
- rst_n low mid-count (inertial, cnt=2 of 3) -> dout=RST_VAL immediately. After release the same input needs a full D ticks to pass.
